seg7_scan_driver: RTL and testbench

//  Consumes the 8-bit out_port bytes of the per-digit 7-segment PIO slaves and drives a

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/seg7_hex_decode.sv | 26 ++
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver: scan FSM states,
// segment bit positions and the hex glyph table used by SEG7_HEX_DECODE_EN builds.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } seg7_state_e;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high glyphs, bit order g..a; b and d are lowercase.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the PIO slaves and the scan driver: digit bytes and enable in,
// multiplexed display pins and the frame snapshot pulse out.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    enable;
  logic [8*NUM_DIGITS-1:0] digit_data;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic                    frame_start;

  modport master (
    output enable, digit_data,
    input  seg_n, dig_n, frame_start
  );

  modport slave (
    input  enable, digit_data,
    output seg_n, dig_n, frame_start
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
// Only instantiated when SEG7_HEX_DECODE_EN is defined.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] pat_c_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph           = hex_to_seg(nibble_i);
    pat_c_o         = '0;
    pat_c_o[SEG_A]  = glyph[0];
    pat_c_o[SEG_B]  = glyph[1];
    pat_c_o[SEG_C]  = glyph[2];
    pat_c_o[SEG_D]  = glyph[3];
    pat_c_o[SEG_E]  = glyph[4];
    pat_c_o[SEG_F]  = glyph[5];
    pat_c_o[SEG_G]  = glyph[6];
    pat_c_o[SEG_DP] = dp_i;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame snapshot and
// inter-digit blanking. Define SEG7_HEX_DECODE_EN for hex decode; default is raw segments.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             reset_n,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned      CNT_W         = $clog2(DIGIT_CYCLES);
  localparam int unsigned      IDX_W         = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

  seg7_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0][7:0]  shadow_q, shadow_d;
  logic [7:0]                  seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]       dig_n_q, dig_n_d;
  logic                        frame_start_q, frame_start_d;
  logic [7:0]                  cur_byte;
  logic [7:0]                  pat_c;

  assign cur_byte = shadow_q[idx_q];

`ifdef SEG7_HEX_DECODE_EN
  logic unused_mid_bits;
  assign unused_mid_bits = ^cur_byte[6:4];

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_byte[3:0]),
    .dp_i     (cur_byte[7]),
    .pat_c_o  (pat_c)
  );
`else
  assign pat_c = cur_byte;
`endif

  // Next state: slot sequencing, frame snapshot and registered pin values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    seg_n_d       = 8'hFF;
    dig_n_d       = '1;
    frame_start_d = 1'b0;

    if (!bus.enable) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (state_q == BLANK && cnt_q == '0 && idx_q == '0) begin
        shadow_d      = bus.digit_data;
        frame_start_d = 1'b1;
      end

      // Pattern only reaches the pins while lit; shadow is stable for the whole ON phase.
      if (state_q == ON) begin
        dig_n_d = ~(NUM_DIGITS'(1) << idx_q);
        seg_n_d = ~pat_c;
      end

      unique case (state_q)
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_BLANK_END) state_d = ON;
        end
        ON: begin
          if (cnt_q == CNT_SLOT_END) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      seg_n_q       <= 8'hFF;
      dig_n_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      seg_n_q       <= seg_n_d;
      dig_n_q       <= dig_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg_n       = seg_n_q;
  assign bus.dig_n       = dig_n_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 blank cycles);
// expectations switch with SEG7_HEX_DECODE_EN.
module tb_seg7_scan_driver;

  localparam int unsigned ND    = 4;
  localparam int unsigned DC    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = ND * DC;

`ifdef SEG7_HEX_DECODE_EN
  localparam logic [31:0] DATA_A = 32'h0F0A_8108;
  localparam logic [31:0] DATA_B = 32'h0E0C_0503;
  localparam logic [31:0] DATA_C = 32'h0000_0002;
  localparam logic [7:0]  TAB_A [4] = '{8'h80, 8'h79, 8'h88, 8'h8E};
  localparam logic [7:0]  TAB_B [4] = '{8'hB0, 8'h92, 8'hC6, 8'h86};
  localparam logic [7:0]  SEG_C0    = 8'hA4;
`else
  localparam logic [31:0] DATA_A = 32'h8040_0201;
  localparam logic [31:0] DATA_B = 32'h0408_1020;
  localparam logic [31:0] DATA_C = 32'h0000_0008;
  localparam logic [7:0]  TAB_A [4] = '{8'hFE, 8'hFD, 8'hBF, 8'h7F};
  localparam logic [7:0]  TAB_B [4] = '{8'hDF, 8'hEF, 8'hF7, 8'hFB};
  localparam logic [7:0]  SEG_C0    = 8'hF7;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   inv_en   = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Expected digit enables p cycles after a frame_start cycle.
  function automatic logic [3:0] exp_dig(input int p);
    logic [3:0] one;
    int slot;
    slot = (p / DC) % ND;
    one  = 4'b0001;
    if ((p % DC) < BC) return 4'hF;
    return ~(one << slot);
  endfunction

  function automatic logic [7:0] exp_seg(input int p, input logic [7:0] tab [4]);
    if ((p % DC) < BC) return 8'hFF;
    return tab[(p / DC) % ND];
  endfunction

  always @(negedge clk) begin
    if (inv_en) begin
      n_checks++;
      if ($countones(~bus.dig_n) > 1 || (bus.dig_n == 4'hF && bus.seg_n !== 8'hFF))
        $display("FAIL invariant t=%0t dig_n=%h seg_n=%h", $time, bus.dig_n, bus.seg_n);
      else
        n_pass++;
    end
  end

  // Step to the next negedge sample where frame_start is high; bounded.
  task automatic sync_frame(input string tag);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL %s_sync frame_start never seen within %0d cycles", tag, 2 * FRAME);
    else n_pass++;
  endtask

  task automatic test_reset();
    int gap;
    n_checks++;
    if (bus.seg_n !== 8'hFF || bus.dig_n !== 4'hF || bus.frame_start !== 1'b0)
      $display("FAIL reset_values seg_n=%h dig_n=%h fs=%b want FF F 0",
               bus.seg_n, bus.dig_n, bus.frame_start);
    else n_pass++;

    reset_n = 1'b1;
    inv_en  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.frame_start !== 1'b1) $display("FAIL first_frame_start got %b want 1", bus.frame_start);
    else n_pass++;

    for (int k = 0; k < 2; k++) begin
      gap = 0;
      for (int c = 1; c <= FRAME + 8 && gap == 0; c++) begin
        @(negedge clk);
        if (bus.frame_start === 1'b1) gap = c;
      end
      n_checks++;
      if (gap != FRAME) $display("FAIL frame_period[%0d] got %0d want %0d", k, gap, FRAME);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    sync_frame("scan");
    for (int p = 0; p < FRAME + DC; p++) begin
      if (p > 0) @(negedge clk);
      n_checks++;
      if (bus.dig_n !== exp_dig(p) || bus.seg_n !== exp_seg(p, TAB_A))
        $display("FAIL scan p=%0d dig_n=%h seg_n=%h want %h %h",
                 p, bus.dig_n, bus.seg_n, exp_dig(p), exp_seg(p, TAB_A));
      else n_pass++;
    end
  endtask

  task automatic test_tearing();
    sync_frame("tear");
    for (int p = 0; p < 2 * FRAME; p++) begin
      if (p > 0) @(negedge clk);
      n_checks++;
      if (p < FRAME) begin
        if (bus.dig_n !== exp_dig(p) || bus.seg_n !== exp_seg(p, TAB_A))
          $display("FAIL tear_old p=%0d dig_n=%h seg_n=%h want %h %h",
                   p, bus.dig_n, bus.seg_n, exp_dig(p), exp_seg(p, TAB_A));
        else n_pass++;
      end else begin
        if (bus.dig_n !== exp_dig(p) || bus.seg_n !== exp_seg(p, TAB_B))
          $display("FAIL tear_new p=%0d dig_n=%h seg_n=%h want %h %h",
                   p, bus.dig_n, bus.seg_n, exp_dig(p), exp_seg(p, TAB_B));
        else n_pass++;
      end
      if (p == 12) bus.digit_data = DATA_B;
    end
  endtask

  task automatic test_enable();
    logic [7:0] tab_c [4];
    tab_c = '{SEG_C0, 8'hFF, 8'hFF, 8'hFF};
    sync_frame("enable");
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.dig_n !== 4'hB || bus.seg_n !== TAB_B[2])
      $display("FAIL enable_digit2 dig_n=%h seg_n=%h want B %h", bus.dig_n, bus.seg_n, TAB_B[2]);
    else n_pass++;

    bus.enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.dig_n !== 4'hF || bus.seg_n !== 8'hFF || bus.frame_start !== 1'b0)
        $display("FAIL enable_dark c=%0d dig_n=%h seg_n=%h fs=%b want F FF 0",
                 c, bus.dig_n, bus.seg_n, bus.frame_start);
      else n_pass++;
    end

    bus.digit_data = DATA_C;
    bus.enable     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.frame_start !== 1'b1) $display("FAIL reenable_fs got %b want 1", bus.frame_start);
    else n_pass++;
    for (int p = 1; p < DC + BC; p++) begin
      @(negedge clk);
      n_checks++;
      if (bus.dig_n !== exp_dig(p) || bus.seg_n !== exp_seg(p, tab_c))
        $display("FAIL reenable_scan p=%0d dig_n=%h seg_n=%h want %h %h",
                 p, bus.dig_n, bus.seg_n, exp_dig(p), exp_seg(p, tab_c));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bus.digit_data = DATA_A;
    sync_frame("rstmid");
    repeat (12) @(negedge clk);
    n_checks++;
    if (bus.dig_n !== 4'hD || bus.seg_n !== TAB_A[1])
      $display("FAIL rstmid_lit dig_n=%h seg_n=%h want D %h", bus.dig_n, bus.seg_n, TAB_A[1]);
    else n_pass++;

    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.dig_n !== 4'hF || bus.seg_n !== 8'hFF || bus.frame_start !== 1'b0)
      $display("FAIL rstmid_dark dig_n=%h seg_n=%h fs=%b want F FF 0",
               bus.dig_n, bus.seg_n, bus.frame_start);
    else n_pass++;

    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.frame_start !== 1'b1) $display("FAIL rstmid_restart_fs got %b want 1", bus.frame_start);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.dig_n !== 4'hE || bus.seg_n !== TAB_A[0])
      $display("FAIL rstmid_digit0 dig_n=%h seg_n=%h want E %h", bus.dig_n, bus.seg_n, TAB_A[0]);
    else n_pass++;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.enable     = 1'b1;
    bus.digit_data = DATA_A;
    repeat (3) @(negedge clk);
    test_reset();
    test_scan();
    test_tearing();
    test_enable();
    test_reset_mid();
    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
